bg_host_seq: RTL and testbench

Host-side sequencer for the background-removal array: the controller end of the `pe` start/done/ack protocol. Per job it latches the job settings, pulses `Start_Sum` to every PE, waits for all sum-done flags and combines the per-PE channel means into one expected background colour (serial accumulate, serial divide). It then broadcasts that colour with the threshold and replacement colour, pulses `Start_BgRemoval`, waits for all removal-done flags and reports completion. It sits between the frame loader and the `pe` instances.

---
 rtl/bg_pkg.sv | 31 +++
 rtl/bg_host_seq_if.sv | 54 +++++
 rtl/bg_serial_div.sv | 68 ++++++
 rtl/bg_host_seq.sv | 194 +++++++++++++++++++
 tb/tb_bg_host_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bg_pkg.sv
// Shared definitions for the background-removal host sequencer.
//   state_t   : sequencer state encoding (also exported on the debug port)
//   PIX_W     : width of one colour channel
//   acc_w(n)  : accumulator width needed to sum n pixel-wide values
package bg_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SUM_GO   = 4'd1,
        ST_SUM_WAIT = 4'd2,
        ST_SUM_ACK  = 4'd3,
        ST_ACCUM    = 4'd4,
        ST_DIVIDE   = 4'd5,
        ST_BG_GO    = 4'd6,
        ST_BG_WAIT  = 4'd7,
        ST_BG_ACK   = 4'd8,
        ST_DONE     = 4'd9,
        ST_ERR      = 4'd10
    } state_t;

    // Sum of n PIX_W-bit values needs PIX_W + clog2(n) bits; never narrower
    // than one pixel so the divider always has a full-width dividend.
    function automatic int acc_w(input int n);
        int w;
        w = PIX_W + $clog2(n);
        return (w < PIX_W) ? PIX_W : w;
    endfunction

endpackage

// File: rtl/bg_host_seq_if.sv
// Bus between the frame loader / PE array and the host sequencer.
//   master : sequencer side (receives job settings, means and done flags;
//            drives start/ack pulses, expected colour, settings and status)
//   slave  : loader / PE side, the mirror image
interface bg_host_seq_if
    import bg_pkg::*;
#(
    parameter int NUM_PE = 2
);
    logic                     Start;
    logic [PIX_W-1:0]         threshold_in;
    logic [PIX_W-1:0]         bg_r_in;
    logic [PIX_W-1:0]         bg_g_in;
    logic [PIX_W-1:0]         bg_b_in;
    logic [PIX_W*NUM_PE-1:0]  red_mean;
    logic [PIX_W*NUM_PE-1:0]  green_mean;
    logic [PIX_W*NUM_PE-1:0]  blue_mean;
    logic [NUM_PE-1:0]        Qsd;
    logic [NUM_PE-1:0]        Qbgd;

    logic                     Start_Sum;
    logic                     Start_BgRemoval;
    logic                     Ack;
    logic [PIX_W-1:0]         red_exp;
    logic [PIX_W-1:0]         green_exp;
    logic [PIX_W-1:0]         blue_exp;
    logic [PIX_W-1:0]         threshold;
    logic [PIX_W-1:0]         desired_bg_r;
    logic [PIX_W-1:0]         desired_bg_g;
    logic [PIX_W-1:0]         desired_bg_b;
    logic                     Busy;
    logic                     Done;
    logic                     Error;
    logic [3:0]               state;

    modport master (
        input  Start, threshold_in, bg_r_in, bg_g_in, bg_b_in,
               red_mean, green_mean, blue_mean, Qsd, Qbgd,
        output Start_Sum, Start_BgRemoval, Ack,
               red_exp, green_exp, blue_exp,
               threshold, desired_bg_r, desired_bg_g, desired_bg_b,
               Busy, Done, Error, state
    );

    modport slave (
        output Start, threshold_in, bg_r_in, bg_g_in, bg_b_in,
               red_mean, green_mean, blue_mean, Qsd, Qbgd,
        input  Start_Sum, Start_BgRemoval, Ack,
               red_exp, green_exp, blue_exp,
               threshold, desired_bg_r, desired_bg_g, desired_bg_b,
               Busy, Done, Error, state
    );

endinterface

// File: rtl/bg_serial_div.sv
// Restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : load dividend_i and begin (divisor_i must stay stable)
//   dividend_i  : W-bit dividend
//   divisor_i   : W-bit divisor, non-zero
//   done_o      : high in the cycle whose step produces the final quotient
//   quot_o      : low QW bits of the quotient, valid while done_o is high
// The division takes exactly W cycles after the start edge; the result is
// presented combinationally with done_o so the caller can capture it at the
// same edge that completes the last step.
module bg_serial_div #(
    parameter int W  = 9,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [W-1:0]  dividend_i,
    input  logic [W-1:0]  divisor_i,
    output logic          done_o,
    output logic [QW-1:0] quot_o
);
    localparam int CW = $clog2(W + 1);

    // quo_q starts as the dividend and shifts left; quotient bits fill in
    // from the bottom as dividend bits leave the top into the remainder.
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [W:0]    trial;

    always_comb begin
        trial = {rem_q, quo_q[W-1]};
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
        if (trial >= {1'b0, divisor_i}) begin
            // True difference is below the divisor, so W-bit wrap is exact.
            rem_d    = trial[W-1:0] - divisor_i;
            quo_d[0] = 1'b1;
        end
    end

    assign done_o = busy_q && (cnt_q == CW'(W - 1));
    assign quot_o = quo_d[QW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bg_host_seq.sv
// Host-side sequencer for the background-removal PE array.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus          : bg_host_seq_if.master
//       Start, job settings in  -> latched settings out
//       per-PE means, Qsd, Qbgd -> Start_Sum, Start_BgRemoval, Ack pulses
//       expected background colour (mean of the PE means, truncated)
//       Busy / Done / Error status and the raw state for debug
// All bus outputs are registers; pulse/status flags are computed from the
// next state so they line up with the state they describe.
module bg_host_seq
    import bg_pkg::*;
#(
    parameter int NUM_PE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic         Clk,
    input  logic         Reset_n,
    bg_host_seq_if.master bus
);
    localparam int ACC_W = acc_w(NUM_PE);
    localparam int IW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            accum_last;
    logic            tmo_hit;
    logic            div_start;
    logic            div_done;
    logic [2:0]      ch_done;

    logic            start_sum_q, start_bg_q, ack_q, busy_q, done_q, err_q;
    logic [PIX_W-1:0] thr_q, bgr_q, bgg_q, bgb_q;

    logic [2:0][PIX_W*NUM_PE-1:0] mean_bus;
    logic [2:0][PIX_W-1:0]        exp_all;

    assign accum_last = (idx_q == IW'(NUM_PE - 1));
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
    assign div_start  = (state_q == ST_ACCUM) && accum_last;
    assign div_done   = &ch_done;
    assign mean_bus   = {bus.blue_mean, bus.green_mean, bus.red_mean};

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.Start) state_d = ST_SUM_GO;
            ST_SUM_GO:   state_d = ST_SUM_WAIT;
            ST_SUM_WAIT: begin
                if (&bus.Qsd)    state_d = ST_SUM_ACK;
                else if (tmo_hit) state_d = ST_ERR;
            end
            ST_SUM_ACK:  state_d = ST_ACCUM;
            ST_ACCUM:    if (accum_last) state_d = ST_DIVIDE;
            ST_DIVIDE:   if (div_done) state_d = ST_BG_GO;
            ST_BG_GO:    state_d = ST_BG_WAIT;
            ST_BG_WAIT: begin
                if (&bus.Qbgd)   state_d = ST_BG_ACK;
                else if (tmo_hit) state_d = ST_ERR;
            end
            ST_BG_ACK:   state_d = ST_DONE;
            ST_DONE:     state_d = bus.Start ? ST_SUM_GO : ST_IDLE;
            ST_ERR:      if (bus.Start) state_d = ST_SUM_GO;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Counters: the timeout count is zero in any non-wait state, which
    // clears it on entry to each wait state; the PE index only runs in ACCUM.
    always_comb begin
        tmo_d = '0;
        idx_d = '0;
        if (state_q == ST_SUM_WAIT || state_q == ST_BG_WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end
        if (state_q == ST_ACCUM) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            idx_q       <= '0;
            start_sum_q <= 1'b0;
            start_bg_q  <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            start_sum_q <= (state_d == ST_SUM_GO);
            start_bg_q  <= (state_d == ST_BG_GO);
            ack_q       <= (state_d == ST_SUM_ACK) || (state_d == ST_BG_ACK);
            busy_q      <= !(state_d == ST_IDLE || state_d == ST_DONE ||
                             state_d == ST_ERR);
            done_q      <= (state_d == ST_DONE);
            err_q       <= (state_d == ST_ERR);
        end
    end

    // Job settings are captured only when a Start is accepted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            thr_q <= '0;
            bgr_q <= '0;
            bgg_q <= '0;
            bgb_q <= '0;
        end else if (state_d == ST_SUM_GO) begin
            thr_q <= bus.threshold_in;
            bgr_q <= bus.bg_r_in;
            bgg_q <= bus.bg_g_in;
            bgb_q <= bus.bg_b_in;
        end
    end

    // ---------------- per-channel accumulate + divide ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [PIX_W-1:0] sel;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [PIX_W-1:0] quot;
        logic [PIX_W-1:0] exp_q;

        always_comb begin
            sel = '0;
            for (int p = 0; p < NUM_PE; p++) begin
                if (idx_q == IW'(p)) begin
                    sel = mean_bus[gi][p*PIX_W +: PIX_W];
                end
            end
        end

        assign acc_d = acc_q + ACC_W'(sel);

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                acc_q <= '0;
            end else if (state_q == ST_SUM_ACK) begin
                acc_q <= '0;
            end else if (state_q == ST_ACCUM) begin
                acc_q <= acc_d;
            end
        end

        // The divider loads acc_d so the final mean added on the last ACCUM
        // cycle is included without an extra pipeline cycle.
        bg_serial_div #(
            .W  (ACC_W),
            .QW (PIX_W)
        ) u_div (
            .clk        (Clk),
            .rst_n      (Reset_n),
            .start_i    (div_start),
            .dividend_i (acc_d),
            .divisor_i  (ACC_W'(NUM_PE)),
            .done_o     (ch_done[gi]),
            .quot_o     (quot)
        );

        // Mean of 8-bit values never exceeds 8 bits, so the low byte is exact.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                exp_q <= '0;
            end else if (state_q == ST_DIVIDE && div_done) begin
                exp_q <= quot;
            end
        end

        assign exp_all[gi] = exp_q;
    end

    // ---------------- bus outputs ----------------
    assign bus.Start_Sum       = start_sum_q;
    assign bus.Start_BgRemoval = start_bg_q;
    assign bus.Ack             = ack_q;
    assign bus.red_exp         = exp_all[0];
    assign bus.green_exp       = exp_all[1];
    assign bus.blue_exp        = exp_all[2];
    assign bus.threshold       = thr_q;
    assign bus.desired_bg_r    = bgr_q;
    assign bus.desired_bg_g    = bgg_q;
    assign bus.desired_bg_b    = bgb_q;
    assign bus.Busy            = busy_q;
    assign bus.Done            = done_q;
    assign bus.Error           = err_q;
    assign bus.state           = state_q;

endmodule

// File: tb/tb_bg_host_seq.sv
// Bench for bg_host_seq: three instances (NUM_PE = 1, 2, 3; the NUM_PE=3
// copy uses TIMEOUT=16). Jobs come from a vector table; expected colours and
// settings are queued when a job is started and compared at Start_BgRemoval.
module tb_bg_host_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      start = '0;
    logic [2:0][2:0] qsd   = '0;
    logic [2:0][2:0] qbgd  = '0;
    logic [23:0]     rm = '0, gm = '0, bm = '0;
    logic [7:0]      thr_in = '0, br_in = '0, bg_in = '0, bb_in = '0;

    logic [2:0]      ss, sbg, ack, dn, er, bsy;
    logic [2:0][7:0] rexp, gexp, bexp, thr_o, dr, dg, db;
    logic [2:0][3:0] st;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int NP = gi + 1;
        bg_host_seq_if #(.NUM_PE(NP)) bus ();
        bg_host_seq #(
            .NUM_PE  (NP),
            .TIMEOUT ((gi == 2) ? 16 : 1024)
        ) u_dut (
            .Clk     (clk),
            .Reset_n (rst_n),
            .bus     (bus)
        );
        assign bus.Start        = start[gi];
        assign bus.threshold_in = thr_in;
        assign bus.bg_r_in      = br_in;
        assign bus.bg_g_in      = bg_in;
        assign bus.bg_b_in      = bb_in;
        assign bus.red_mean     = rm[8*NP-1:0];
        assign bus.green_mean   = gm[8*NP-1:0];
        assign bus.blue_mean    = bm[8*NP-1:0];
        assign bus.Qsd          = qsd[gi][NP-1:0];
        assign bus.Qbgd         = qbgd[gi][NP-1:0];
        assign ss[gi]    = bus.Start_Sum;
        assign sbg[gi]   = bus.Start_BgRemoval;
        assign ack[gi]   = bus.Ack;
        assign dn[gi]    = bus.Done;
        assign er[gi]    = bus.Error;
        assign bsy[gi]   = bus.Busy;
        assign rexp[gi]  = bus.red_exp;
        assign gexp[gi]  = bus.green_exp;
        assign bexp[gi]  = bus.blue_exp;
        assign thr_o[gi] = bus.threshold;
        assign dr[gi]    = bus.desired_bg_r;
        assign dg[gi]    = bus.desired_bg_g;
        assign db[gi]    = bus.desired_bg_b;
        assign st[gi]    = bus.state;
    end

    typedef struct {
        int         k;
        logic [23:0] rm, gm, bm;
        logic [7:0] thr, br, bgc, bb;
        logic [7:0] er, eg, eb;
    } vec_t;

    typedef struct {
        int         k;
        logic [7:0] er, eg, eb, thr, br, bgc, bb;
    } exp_t;

    vec_t vt[6];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic do_start(input vec_t v, input bit push);
        exp_t e;
        rm = v.rm; gm = v.gm; bm = v.bm;
        thr_in = v.thr; br_in = v.br; bg_in = v.bgc; bb_in = v.bb;
        @(negedge clk);
        start[v.k] = 1'b1;
        if (push) begin
            e.k = v.k; e.er = v.er; e.eg = v.eg; e.eb = v.eb;
            e.thr = v.thr; e.br = v.br; e.bgc = v.bgc; e.bb = v.bb;
            sbq.push_back(e);
        end
        @(negedge clk);
        start[v.k] = 1'b0;
        chk("start_sum_high", ss[v.k], 1);
        chk("busy_after_start", bsy[v.k], 1);
        chk("error_clear_on_start", er[v.k], 0);
        @(negedge clk);
        chk("start_sum_single", ss[v.k], 0);
        chk("state_sum_wait", st[v.k], 2);
    endtask

    // Raise all sum-done flags; check Ack next cycle and Start_BgRemoval at
    // the accumulate+divide latency, then compare against the scoreboard.
    task automatic sum_phase(input int k);
        int   j;
        bit   found;
        int   want;
        exp_t e;
        found = 1'b0;
        want  = 2 + (k + 1) + (8 + k);
        qsd[k] = 3'b111;
        for (j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk("sum_ack", ack[k], 1);
                qsd[k] = 3'b000;
            end
            if (sbg[k]) begin
                found = 1'b1;
                break;
            end
        end
        chk("bg_go_latency", found ? j : 0, want);
        if (sbq.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("sb_dut", k, e.k);
            chk("red_exp", rexp[k], e.er);
            chk("green_exp", gexp[k], e.eg);
            chk("blue_exp", bexp[k], e.eb);
            chk("threshold", thr_o[k], e.thr);
            chk("desired_bg", {dr[k], dg[k], db[k]}, {8'd0, e.br, e.bgc, e.bb});
        end
        @(negedge clk);
        chk("start_bg_single", sbg[k], 0);
        chk("state_bg_wait", st[k], 7);
    endtask

    task automatic bg_phase(input int k);
        qbgd[k] = 3'b111;
        @(negedge clk);
        chk("bg_ack", ack[k], 1);
        chk("done_not_early", dn[k], 0);
        qbgd[k] = 3'b000;
        @(negedge clk);
        chk("done", dn[k], 1);
        chk("busy_in_done", bsy[k], 0);
        chk("ack_single", ack[k], 0);
        @(negedge clk);
        chk("done_single", dn[k], 0);
        chk("idle_after_done", st[k], 0);
    endtask

    task automatic run_job(input vec_t v, input int n);
        do_start(v, 1'b1);
        sum_phase(v.k);
        bg_phase(v.k);
        $display("job %0d: npe=%0d exp=%0d/%0d/%0d thr=%0d bg=%0d/%0d/%0d",
                 n, v.k + 1, rexp[v.k], gexp[v.k], bexp[v.k],
                 thr_o[v.k], dr[v.k], dg[v.k], db[v.k]);
    endtask

    initial begin
        bit flag;
        int cnt;

        vt[0] = '{0, 24'd96, 24'd99, 24'd148, 8'd60, 8'd106, 8'd168, 8'd79, 8'd96, 8'd99, 8'd148};
        vt[1] = '{1, {8'd0, 8'd204, 8'd61}, {8'd0, 8'd20, 8'd10}, {8'd0, 8'd254, 8'd255},
                  8'd7, 8'd1, 8'd2, 8'd3, 8'd132, 8'd15, 8'd254};
        vt[2] = '{2, {8'd255, 8'd255, 8'd255}, {8'd1, 8'd0, 8'd0}, {8'd31, 8'd20, 8'd10},
                  8'd200, 8'd9, 8'd8, 8'd7, 8'd255, 8'd0, 8'd20};
        vt[3] = '{1, {8'd0, 8'd0, 8'd1}, {8'd0, 8'd255, 8'd255}, {8'd0, 8'd3, 8'd100},
                  8'd255, 8'd250, 8'd251, 8'd252, 8'd0, 8'd255, 8'd51};
        vt[4] = '{0, 24'd0, 24'd255, 24'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd1};
        vt[5] = '{2, {8'd100, 8'd50, 8'd0}, {8'd7, 8'd7, 8'd8}, {8'd2, 8'd2, 8'd2},
                  8'd33, 8'd44, 8'd55, 8'd66, 8'd50, 8'd7, 8'd2};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_state", st[k], 0);
            chk("rst_flags", {ss[k], sbg[k], ack[k], dn[k], er[k], bsy[k]}, 0);
            chk("rst_exp", {rexp[k], gexp[k], bexp[k]}, 0);
            chk("rst_settings", {thr_o[k], dr[k], dg[k], db[k]}, 0);
        end
        rst_n = 1'b1;

        // ---- table-driven jobs ----
        for (int n = 0; n < 5; n++) begin
            run_job(vt[n], n);
        end

        // ---- partial sum-done flags are not remembered ----
        do_start(vt[1], 1'b1);
        qsd[1] = 3'b001;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack[1] || st[1] != 4'd2) flag = 1'b1;
        end
        chk("partial_qsd_hold", flag, 0);
        sum_phase(1);
        bg_phase(1);
        $display("job partial_qsd: npe=2 red_exp=%0d", rexp[1]);

        // ---- BG_WAIT timeout on the TIMEOUT=16 instance ----
        do_start(vt[2], 1'b1);
        sum_phase(2);
        flag = 1'b0;
        for (int i = 2; i <= 17; i++) begin
            @(negedge clk);
            if (ack[2]) flag = 1'b1;
            if (i == 16) begin
                chk("tmo_not_early", er[2], 0);
                chk("tmo_state_wait", st[2], 7);
            end
        end
        chk("tmo_error", er[2], 1);
        chk("tmo_busy", bsy[2], 0);
        chk("tmo_no_ack", flag, 0);
        repeat (3) @(negedge clk);
        chk("tmo_error_held", er[2], 1);
        $display("job timeout: npe=3 error=%0d", er[2]);
        run_job(vt[5], 5);

        // ---- asynchronous reset during DIVIDE ----
        do_start(vt[3], 1'b0);
        qsd[1] = 3'b111;
        @(negedge clk);
        qsd[1] = 3'b000;
        repeat (5) @(negedge clk);
        chk("in_divide", st[1], 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", st[1], 0);
        chk("arst_flags", {ss[1], sbg[1], ack[1], dn[1], er[1], bsy[1]}, 0);
        chk("arst_exp", {rexp[1], gexp[1], bexp[1]}, 0);
        chk("arst_settings", {thr_o[1], dr[1], dg[1], db[1]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_stays_idle", st[1], 0);
        $display("job reset_in_divide: npe=2 state=%0d", st[1]);

        // ---- Start ignored during BG_WAIT ----
        do_start(vt[3], 1'b1);
        sum_phase(1);
        thr_in = 8'hAA;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        flag = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (ss[1]) cnt++;
            if (st[1] != 4'd7) flag = 1'b1;
        end
        chk("start_ignored_no_sum", cnt, 0);
        chk("start_ignored_state", flag, 0);
        chk("settings_held", thr_o[1], vt[3].thr);
        chk("exp_held", {rexp[1], gexp[1], bexp[1]}, {8'd0, vt[3].er, vt[3].eg, vt[3].eb});
        bg_phase(1);
        $display("job start_in_bg_wait: npe=2 exp=%0d/%0d/%0d", rexp[1], gexp[1], bexp[1]);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
